// File: rtl/sub32_pipe_if.sv
// rtl/sub32_pipe_if.sv - operand/result handshake bundle for sub32_pipe
// borrow exists only when SUB32_PIPE_BORROW_EN is defined.
interface sub32_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] a;
`ifdef SUB32_PIPE_BORROW_EN
  logic             borrow;
`endif

  modport master (
    output in_valid, c, b, out_ready,
`ifdef SUB32_PIPE_BORROW_EN
    input  borrow,
`endif
    input  in_ready, out_valid, a
  );

  modport slave (
    input  in_valid, c, b, out_ready,
`ifdef SUB32_PIPE_BORROW_EN
    output borrow,
`endif
    output in_ready, out_valid, a
  );
endinterface

// File: rtl/sub32_pipe.sv
// rtl/sub32_pipe.sv - two-stage valid/ready pipeline recovering a = c - b
// Optional registered borrow output under SUB32_PIPE_BORROW_EN.
module sub32_pipe #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          rst_n,
  sub32_pipe_if.slave  bus
);
  logic             p0_valid;
  logic [WIDTH-1:0] p0_c;
  logic [WIDTH-1:0] p0_b;
  logic             p1_valid;
  logic [WIDTH-1:0] p1_a;
  logic [WIDTH-1:0] diff;
  logic             p1_load;
  logic             in_xfer;

  // p1 can take new data whenever it is empty or its content leaves this cycle
  assign p1_load      = !p1_valid || bus.out_ready;
  assign bus.in_ready = !p0_valid || p1_load;
  assign in_xfer      = bus.in_valid && bus.in_ready;

`ifdef SUB32_PIPE_BORROW_EN
  logic p1_borrow;
  logic diff_borrow;
  assign {diff_borrow, diff} = {1'b0, p0_c} - {1'b0, p0_b};
  assign bus.borrow          = p1_borrow;
`else
  assign diff = p0_c - p0_b;
`endif

  assign bus.a         = p1_a;
  assign bus.out_valid = p1_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p0_valid <= 1'b0;
      p0_c     <= '0;
      p0_b     <= '0;
    end else if (in_xfer) begin
      p0_valid <= 1'b1;
      p0_c     <= bus.c;
      p0_b     <= bus.b;
    end else if (p1_load) begin
      p0_valid <= 1'b0;
    end
  end

  // Data only moves with a valid token so an emptied stage keeps its old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_valid <= 1'b0;
      p1_a     <= '0;
    end else if (p1_load) begin
      p1_valid <= p0_valid;
      if (p0_valid) begin
        p1_a <= diff;
      end
    end
  end

`ifdef SUB32_PIPE_BORROW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_borrow <= 1'b0;
    end else if (p1_load && p0_valid) begin
      p1_borrow <= diff_borrow;
    end
  end
`endif
endmodule

// File: tb/tb_sub32_pipe.sv
// tb/tb_sub32_pipe.sv - directed self-checking bench for sub32_pipe
// Borrow checks are compiled in when SUB32_PIPE_BORROW_EN is defined.
module tb_sub32_pipe;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  sub32_pipe_if #(.WIDTH(32)) bus ();

  sub32_pipe #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_borrow(input string tag, input logic exp);
`ifdef SUB32_PIPE_BORROW_EN
    chk(tag, 32'(bus.borrow), 32'(exp));
`else
    if (exp === 1'bx) $display("unused %s", tag);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] cv, input logic [31:0] bv);
    bus.in_valid = v;
    bus.c        = cv;
    bus.b        = bv;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    bus.out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_a", bus.a, 32'h0);
    chk_borrow("reset_borrow", 1'b0);
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
    step();

    // 5 - 3, two edges from acceptance
    drive(1'b1, 32'h5, 32'h3);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("lat_not_yet", 32'(bus.out_valid), 32'd0);
    step();
    chk("lat_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_a", bus.a, 32'h2);
    chk_borrow("lat_borrow", 1'b0);

    // 0 - 1 wraps
    drive(1'b1, 32'h0, 32'h1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("wrap_valid", 32'(bus.out_valid), 32'd1);
    chk("wrap_a", bus.a, 32'hFFFF_FFFF);
    chk_borrow("wrap_borrow", 1'b1);

    // back-to-back stream c=i*3, b=i
    for (int k = 0; k <= 8; k++) begin
      if (k < 8) drive(1'b1, 32'(k * 3), 32'(k));
      else       drive(1'b0, 32'h0, 32'h0);
      #1;
      chk("stream_in_ready", 32'(bus.in_ready), 32'd1);
      step();
      if (k >= 1) begin
        chk("stream_valid", 32'(bus.out_valid), 32'd1);
        chk("stream_a", bus.a, 32'((k - 1) * 2));
        chk_borrow("stream_borrow", 1'b0);
      end
    end
    step();
    chk("stream_drained", 32'(bus.out_valid), 32'd0);

    // stall with three offered pairs
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd100, 32'd1);
    #1;
    chk("stall_rdy0", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b1, 32'd200, 32'd2);
    #1;
    chk("stall_rdy1", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b1, 32'd300, 32'd3);
    #1;
    chk("stall_full_rdy", 32'(bus.in_ready), 32'd0);
    chk("stall_valid", 32'(bus.out_valid), 32'd1);
    chk("stall_a", bus.a, 32'd99);
    step();
    chk("stall_hold_rdy", 32'(bus.in_ready), 32'd0);
    chk("stall_hold_a", bus.a, 32'd99);
    bus.out_ready = 1'b1;
    #1;
    chk("stall_release_rdy", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("drain_a1", bus.a, 32'd198);
    step();
    chk("drain_a2", bus.a, 32'd297);
    chk("drain_v2", 32'(bus.out_valid), 32'd1);
    step();
    chk("drain_empty", 32'(bus.out_valid), 32'd0);

    // full pipe, simultaneous in and out transfer
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd50, 32'd10);
    step();
    drive(1'b1, 32'd60, 32'd10);
    step();
    drive(1'b1, 32'd70, 32'd10);
    #1;
    chk("full_rdy_low", 32'(bus.in_ready), 32'd0);
    chk("full_a", bus.a, 32'd40);
    bus.out_ready = 1'b1;
    #1;
    chk("full_rdy_high", 32'(bus.in_ready), 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("swap_a1", bus.a, 32'd50);
    step();
    chk("swap_a2", bus.a, 32'd60);
    step();
    chk("swap_empty", 32'(bus.out_valid), 32'd0);

    // asynchronous reset with both stages full
    bus.out_ready = 1'b0;
    drive(1'b1, 32'd9, 32'd20);
    step();
    drive(1'b1, 32'd8, 32'd1);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("prerst_valid", 32'(bus.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_a", bus.a, 32'h0);
    chk_borrow("arst_borrow", 1'b0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("arst_rdy", 32'(bus.in_ready), 32'd1);
    step();
    chk("post_rst_empty1", 32'(bus.out_valid), 32'd0);
    step();
    chk("post_rst_empty2", 32'(bus.out_valid), 32'd0);
    drive(1'b1, 32'd9, 32'd4);
    step();
    drive(1'b0, 32'h0, 32'h0);
    chk("post_rst_lat", 32'(bus.out_valid), 32'd0);
    step();
    chk("post_rst_valid", 32'(bus.out_valid), 32'd1);
    chk("post_rst_a", bus.a, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
